// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: game_state encodings, BCD digit
// width, default playfield coordinates and a constant-to-BCD digit helper.
package snake_pkg;

  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_PLAY = 2'b01;
  localparam logic [1:0] STATE_OVER = 2'b10;

  localparam int BCD_DIGIT_W = 4;

  localparam int DEFAULT_COORD_W     = 10;
  localparam int DEFAULT_START_X     = 400;
  localparam int DEFAULT_START_Y     = 200;
  localparam int DEFAULT_SLOT_STEP_X = 64;

  // Decimal digit idx of an elaboration-time constant.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_const_digit(input int unsigned value,
                                                             input int unsigned idx);
    int unsigned v;
    v = value;
    for (int unsigned k = 0; k < idx; k++) v = v / 10;
    return BCD_DIGIT_W'(v % 10);
  endfunction

endpackage

// File: rtl/apple_score_engine_bcd_adder.sv
// Multi-digit BCD adder of a constant; a carry out of the top digit
// saturates the result at all nines.
module bcd_adder
  import snake_pkg::*;
#(
  parameter int          DIGITS = 4,
  parameter int unsigned ADDEND = 4
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] value,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum
);

  logic [BCD_DIGIT_W*DIGITS-1:0] raw;
  logic                          carry;
  logic [BCD_DIGIT_W:0]          digit_sum;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    raw       = '0;
    carry     = 1'b0;
    digit_sum = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digit_sum = {1'b0, value[d*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {1'b0, bcd_const_digit(ADDEND, unsigned'(d))}
                + {{BCD_DIGIT_W{1'b0}}, carry};
      if (digit_sum > 5'd9) begin
        raw[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(digit_sum - 5'd10);
        carry = 1'b1;
      end else begin
        raw[d*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_sum[3:0];
        carry = 1'b0;
      end
    end
    sum = carry ? {DIGITS{4'h9}} : raw;
  end

endmodule

// File: rtl/apple_score_engine.sv
// Apple slots, hit detection, score/length keeping and game FSM for the snake game.
// Define APPLE_HIGH_SCORE_EN to track the high score on hi_bcd (otherwise hi_bcd is 0).
module apple_score_engine
  import snake_pkg::*;
#(
  parameter int NUM_APPLES       = 2,
  parameter int COORD_W          = DEFAULT_COORD_W,
  parameter int HIT_RADIUS       = 4,
  parameter int POINTS_PER_APPLE = 4,
  parameter int SCORE_DIGITS     = 4,
  parameter int MAX_LENGTH       = 100,
  parameter int START_X          = DEFAULT_START_X,
  parameter int START_Y          = DEFAULT_START_Y,
  parameter int SLOT_STEP_X      = DEFAULT_SLOT_STEP_X
) (
  input  logic                               clock_100Mhz,
  input  logic                               reset,
  input  logic                               step_tick,
  input  logic                               start,
  input  logic                               self_hit,
  input  logic [COORD_W-1:0]                 head_x,
  input  logic [COORD_W-1:0]                 head_y,
  input  logic [COORD_W-1:0]                 rand_x,
  input  logic [COORD_W-1:0]                 rand_y,
  output logic [NUM_APPLES*COORD_W-1:0]      apple_x,
  output logic [NUM_APPLES*COORD_W-1:0]      apple_y,
  output logic [9:0]                         length,
  output logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] score_bcd,
  output logic [BCD_DIGIT_W*SCORE_DIGITS-1:0] hi_bcd,
  output logic                               eaten_pulse,
  output logic [1:0]                         game_state
);

  localparam int                 SCORE_W = BCD_DIGIT_W * SCORE_DIGITS;
  localparam logic [9:0]         MAX_LEN = 10'(MAX_LENGTH);
  localparam logic [COORD_W:0]   RADIUS  = (COORD_W+1)'(HIT_RADIUS);
  localparam logic [COORD_W-1:0] INIT_Y  = COORD_W'(START_Y);

  logic [1:0]            state;
  logic [COORD_W-1:0]    slot_x [NUM_APPLES];
  logic [COORD_W-1:0]    slot_y [NUM_APPLES];
  logic [SCORE_W-1:0]    score;
  logic [SCORE_W-1:0]    score_inc;
  logic [9:0]            len;
  logic                  eaten;
  logic [NUM_APPLES-1:0] hit_raw;
  logic [NUM_APPLES-1:0] hit_sel;

  function automatic logic [COORD_W-1:0] init_x(input int i);
    return COORD_W'(START_X + i * SLOT_STEP_X);
  endfunction

  // One extra bit keeps the difference signed, so nothing wraps at 0 or the top coordinate.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[COORD_W] ? -d : d;
  endfunction

  for (genvar i = 0; i < NUM_APPLES; i++) begin : g_slot
    assign apple_x[i*COORD_W +: COORD_W] = slot_x[i];
    assign apple_y[i*COORD_W +: COORD_W] = slot_y[i];
    assign hit_raw[i] = (abs_diff(head_x, slot_x[i]) <= RADIUS)
                     && (abs_diff(head_y, slot_y[i]) <= RADIUS);
  end

  // Isolate the lowest set bit: the lowest-index slot wins a shared hit.
  assign hit_sel = hit_raw & (-hit_raw);

  bcd_adder #(
    .DIGITS (SCORE_DIGITS),
    .ADDEND (POINTS_PER_APPLE)
  ) u_score_add (
    .value (score),
    .sum   (score_inc)
  );

  // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state <= STATE_IDLE;
      score <= '0;
      len   <= 10'd1;
      eaten <= 1'b0;
      // NOTE: the slot array is a handful of flops that define the board layout, so it is reset like any other state.
      for (int i = 0; i < NUM_APPLES; i++) begin
        slot_x[i] <= init_x(i);
        slot_y[i] <= INIT_Y;
      end
    end else begin
      eaten <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            state <= STATE_PLAY;
            score <= '0;
            len   <= 10'd1;
            for (int i = 0; i < NUM_APPLES; i++) begin
              slot_x[i] <= init_x(i);
              slot_y[i] <= INIT_Y;
            end
          end
        end
        STATE_PLAY: begin
          if (step_tick) begin
            if (self_hit || len == MAX_LEN) begin
              state <= STATE_OVER;
            end else if (|hit_raw) begin
              for (int i = 0; i < NUM_APPLES; i++) begin
                if (hit_sel[i]) begin
                  slot_x[i] <= rand_x;
                  slot_y[i] <= rand_y;
                end
              end
              len   <= (len >= MAX_LEN) ? MAX_LEN : len + 10'd1;
              score <= score_inc;
              eaten <= 1'b1;
            end
          end
        end
        STATE_OVER: begin
          if (start) state <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

`ifdef APPLE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi;

  // BCD digits are weighted like binary nibbles, so a plain unsigned compare is digit-wise.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      hi <= '0;
    end else if (score > hi) begin
      hi <= score;
    end
  end

  assign hi_bcd = hi;
`else
  assign hi_bcd = '0;
`endif

  assign game_state  = state;
  assign score_bcd   = score;
  assign length      = len;
  assign eaten_pulse = eaten;

endmodule

// File: tb/tb_apple_score_engine.sv
// Self-checking bench for apple_score_engine: directed scenarios plus a
// randomized run, all checked against an integer-level game model.
module tb_apple_score_engine;

  localparam int NA   = 2;
  localparam int MAXL = 100;
`ifdef APPLE_HIGH_SCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clock_100Mhz = 1'b0;
  logic        reset = 1'b0;
  logic        step_tick = 1'b0;
  logic        start = 1'b0;
  logic        self_hit = 1'b0;
  logic [9:0]  head_x = '0, head_y = '0, rand_x = '0, rand_y = '0;
  logic [19:0] apple_x, apple_y;
  logic [9:0]  length;
  logic [15:0] score_bcd, hi_bcd;
  logic        eaten_pulse;
  logic [1:0]  game_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state kept as plain integers (decimal score, not BCD)
  int m_state, m_score, m_hi, m_len;
  int m_ax[NA], m_ay[NA];
  bit m_eaten;

  always #5 clock_100Mhz = ~clock_100Mhz;

  apple_score_engine dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .step_tick    (step_tick),
    .start        (start),
    .self_hit     (self_hit),
    .head_x       (head_x),
    .head_y       (head_y),
    .rand_x       (rand_x),
    .rand_y       (rand_y),
    .apple_x      (apple_x),
    .apple_y      (apple_y),
    .length       (length),
    .score_bcd    (score_bcd),
    .hi_bcd       (hi_bcd),
    .eaten_pulse  (eaten_pulse),
    .game_state   (game_state)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  function automatic logic [84:0] model_outputs();
    return {2'(m_state), to_bcd(m_score), to_bcd(m_hi), 10'(m_len), m_eaten,
            10'(m_ax[1]), 10'(m_ax[0]), 10'(m_ay[1]), 10'(m_ay[0])};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_len = 1; m_eaten = 0;
    for (int i = 0; i < NA; i++) begin
      m_ax[i] = 400 + 64 * i;
      m_ay[i] = 200;
    end
  endtask

  task automatic model_edge(input bit st, input bit sr, input bit sh,
                            input int hx, input int hy, input int rx, input int ry);
    int hit;
    hit = -1;
    if (HI_EN && m_score > m_hi) m_hi = m_score;
    m_eaten = 0;
    case (m_state)
      0: if (sr) begin
           m_state = 1; m_score = 0; m_len = 1;
           for (int i = 0; i < NA; i++) begin
             m_ax[i] = 400 + 64 * i;
             m_ay[i] = 200;
           end
         end
      1: if (st) begin
           if (sh || m_len == MAXL) begin
             m_state = 2;
           end else begin
             for (int i = NA - 1; i >= 0; i--)
               if (iabs(hx - m_ax[i]) <= 4 && iabs(hy - m_ay[i]) <= 4) hit = i;
             if (hit >= 0) begin
               m_ax[hit] = rx; m_ay[hit] = ry;
               m_len   = (m_len + 1 > MAXL) ? MAXL : m_len + 1;
               m_score = (m_score + 4 > 9999) ? 9999 : m_score + 4;
               m_eaten = 1;
             end
           end
         end
      default: if (sr) m_state = 0;
    endcase
  endtask

  // Drive one clock's inputs, advance the model at the edge, settle 1 ns after it.
  task automatic cycle(input bit st, input bit sr, input bit sh,
                       input int hx, input int hy, input int rx, input int ry);
    step_tick = st; start = sr; self_hit = sh;
    head_x = 10'(hx); head_y = 10'(hy); rand_x = 10'(rx); rand_y = 10'(ry);
    @(posedge clock_100Mhz);
    model_edge(st, sr, sh, hx, hy, rx, ry);
    #1;
    step_tick = 1'b0; start = 1'b0; self_hit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
  endtask

  task automatic fresh_play();
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    model_reset();
    n_checks++; if (game_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", game_state); end
    n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score got %h want 0000", score_bcd); end
    n_checks++; if (hi_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_hi got %h want 0000", hi_bcd); end
    n_checks++; if (length !== 10'd1) begin n_fail++; $display("FAIL reset_length got %0d want 1", length); end
    n_checks++; if (eaten_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_eaten got %b want 0", eaten_pulse); end
    n_checks++; if (apple_x !== {10'd464, 10'd400} || apple_y !== {10'd200, 10'd200}) begin
      n_fail++; $display("FAIL reset_apples got x=%h y=%h want x=%h y=%h", apple_x, apple_y, {10'd464, 10'd400}, {10'd200, 10'd200});
    end
    @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_start_eat();
    int rx, ry;
    rx = $urandom_range(0, 1023);
    ry = $urandom_range(0, 1023);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (game_state !== 2'b01) begin n_fail++; $display("FAIL start_state got %b want 01", game_state); end
    cycle(1, 0, 0, 400, 200, rx, ry);
    n_checks++; if (eaten_pulse !== 1'b1) begin n_fail++; $display("FAIL eat_pulse got %b want 1", eaten_pulse); end
    n_checks++; if (length !== 10'd2) begin n_fail++; $display("FAIL eat_length got %0d want 2", length); end
    n_checks++; if (score_bcd !== 16'h0004) begin n_fail++; $display("FAIL eat_score got %h want 0004", score_bcd); end
    n_checks++; if (apple_x[9:0] !== 10'(rx) || apple_y[9:0] !== 10'(ry)) begin
      n_fail++; $display("FAIL eat_respawn got (%0d,%0d) want (%0d,%0d)", apple_x[9:0], apple_y[9:0], rx, ry);
    end
    cycle(0, 0, 0, 400, 200, 0, 0);
    n_checks++; if (eaten_pulse !== 1'b0 || length !== 10'd2 || score_bcd !== 16'h0004) begin
      n_fail++; $display("FAIL eat_hold got pulse=%b len=%0d score=%h want 0/2/0004", eaten_pulse, length, score_bcd);
    end
    n_checks++; if (hi_bcd !== (HI_EN ? 16'h0004 : 16'h0000)) begin
      n_fail++; $display("FAIL eat_hi got %h want %h", hi_bcd, HI_EN ? 16'h0004 : 16'h0000);
    end
  endtask

  task automatic test_hit_window();
    fresh_play();
    cycle(1, 0, 0, 405, 200, 700, 700);
    n_checks++; if (eaten_pulse !== 1'b0 || score_bcd !== 16'h0000) begin
      n_fail++; $display("FAIL win_x5 got pulse=%b score=%h want 0/0000", eaten_pulse, score_bcd);
    end
    cycle(1, 0, 0, 404, 196, 2, 300);
    n_checks++; if (eaten_pulse !== 1'b1 || apple_x[9:0] !== 10'd2) begin
      n_fail++; $display("FAIL win_corner got pulse=%b x0=%0d want 1/2", eaten_pulse, apple_x[9:0]);
    end
    cycle(1, 0, 0, 1020, 300, 700, 700);
    n_checks++; if (eaten_pulse !== 1'b0 || score_bcd !== 16'h0004) begin
      n_fail++; $display("FAIL win_nowrap got pulse=%b score=%h want 0/0004", eaten_pulse, score_bcd);
    end
    cycle(1, 0, 0, 6, 296, 700, 700);
    n_checks++; if (eaten_pulse !== 1'b1 || score_bcd !== 16'h0008) begin
      n_fail++; $display("FAIL win_low_edge got pulse=%b score=%h want 1/0008", eaten_pulse, score_bcd);
    end
  endtask

  task automatic test_lowest_slot();
    fresh_play();
    cycle(1, 0, 0, 464, 200, 402, 200);
    n_checks++; if (apple_x !== {10'd402, 10'd400}) begin
      n_fail++; $display("FAIL slot1_respawn got %h want %h", apple_x, {10'd402, 10'd400});
    end
    cycle(1, 0, 0, 401, 200, 50, 50);
    n_checks++; if (apple_x !== {10'd402, 10'd50} || apple_y !== {10'd200, 10'd50}) begin
      n_fail++; $display("FAIL lowest_wins got x=%h y=%h want x=%h y=%h", apple_x, apple_y, {10'd402, 10'd50}, {10'd200, 10'd50});
    end
    n_checks++; if (score_bcd !== 16'h0008 || length !== 10'd3) begin
      n_fail++; $display("FAIL lowest_score got score=%h len=%0d want 0008/3", score_bcd, length);
    end
  endtask

  task automatic test_over_restart();
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (game_state !== 2'b01) begin n_fail++; $display("FAIL play_ignores_start got %b want 01", game_state); end
    cycle(1, 0, 1, 50, 50, 9, 9);
    n_checks++; if (game_state !== 2'b10 || score_bcd !== 16'h0008 || eaten_pulse !== 1'b0 || apple_x[9:0] !== 10'd50) begin
      n_fail++; $display("FAIL self_hit got st=%b score=%h pulse=%b x0=%0d want 10/0008/0/50", game_state, score_bcd, eaten_pulse, apple_x[9:0]);
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (game_state !== 2'b00) begin n_fail++; $display("FAIL over_to_idle got %b want 00", game_state); end
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (game_state !== 2'b01 || score_bcd !== 16'h0000 || length !== 10'd1 || apple_x !== {10'd464, 10'd400}) begin
      n_fail++; $display("FAIL restart got st=%b score=%h len=%0d x=%h want 01/0000/1/%h", game_state, score_bcd, length, apple_x, {10'd464, 10'd400});
    end
    n_checks++; if (hi_bcd !== (HI_EN ? 16'h0008 : 16'h0000)) begin
      n_fail++; $display("FAIL hi_retained got %h want %h", hi_bcd, HI_EN ? 16'h0008 : 16'h0000);
    end
  endtask

  task automatic test_score_carry();
    fresh_play();
    for (int k = 0; k < 25; k++)
      cycle(1, 0, 0, m_ax[0], m_ay[0], $urandom_range(0, 1023), $urandom_range(0, 1023));
    n_checks++; if (score_bcd !== 16'h0100 || length !== 10'd26) begin
      n_fail++; $display("FAIL carry_score got score=%h len=%0d want 0100/26", score_bcd, length);
    end
    n_checks++; if (hi_bcd !== (HI_EN ? 16'h0096 : 16'h0000)) begin
      n_fail++; $display("FAIL carry_hi_lag got %h want %h", hi_bcd, HI_EN ? 16'h0096 : 16'h0000);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (hi_bcd !== (HI_EN ? 16'h0100 : 16'h0000)) begin
      n_fail++; $display("FAIL carry_hi got %h want %h", hi_bcd, HI_EN ? 16'h0100 : 16'h0000);
    end
  endtask

  task automatic test_max_length();
    fresh_play();
    for (int k = 0; k < 99; k++)
      cycle(1, 0, 0, m_ax[0], m_ay[0], $urandom_range(0, 1023), $urandom_range(0, 1023));
    n_checks++; if (length !== 10'd100 || score_bcd !== 16'h0396) begin
      n_fail++; $display("FAIL max_fill got len=%0d score=%h want 100/0396", length, score_bcd);
    end
    cycle(1, 0, 0, m_ax[0], m_ay[0], 1, 1);
    n_checks++; if (game_state !== 2'b10 || eaten_pulse !== 1'b0 || score_bcd !== 16'h0396 || length !== 10'd100) begin
      n_fail++; $display("FAIL max_over got st=%b pulse=%b score=%h len=%0d want 10/0/0396/100", game_state, eaten_pulse, score_bcd, length);
    end
  endtask

  task automatic test_reset_mid_play();
    fresh_play();
    cycle(1, 0, 0, 400, 200, 300, 300);
    step_tick = 1'b1;
    head_x = 10'(m_ax[0]); head_y = 10'(m_ay[0]);
    rand_x = 10'd7; rand_y = 10'd7;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({game_state, score_bcd, hi_bcd, length, eaten_pulse} !== {2'b00, 16'h0000, 16'h0000, 10'd1, 1'b0}) begin
      n_fail++; $display("FAIL midreset_regs got st=%b score=%h hi=%h len=%0d pulse=%b", game_state, score_bcd, hi_bcd, length, eaten_pulse);
    end
    n_checks++; if (apple_x !== {10'd464, 10'd400} || apple_y !== {10'd200, 10'd200}) begin
      n_fail++; $display("FAIL midreset_apples got x=%h y=%h", apple_x, apple_y);
    end
    @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
    step_tick = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({game_state, score_bcd, hi_bcd, length, eaten_pulse, apple_x, apple_y} !== model_outputs()) begin
      n_fail++; $display("FAIL midreset_after got %h want %h",
                         {game_state, score_bcd, hi_bcd, length, eaten_pulse, apple_x, apple_y}, model_outputs());
    end
  endtask

  task automatic test_random();
    bit st, sr, sh;
    int hx, hy, j;
    fresh_play();
    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      sr = (m_state == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      sh = ($urandom_range(0, 15) == 0);
      j  = $urandom_range(0, NA - 1);
      if ($urandom_range(0, 3) != 0) begin
        hx = clamp(m_ax[j] + $urandom_range(0, 10) - 5);
        hy = clamp(m_ay[j] + $urandom_range(0, 10) - 5);
      end else begin
        hx = $urandom_range(0, 1023);
        hy = $urandom_range(0, 1023);
      end
      cycle(st, sr, sh, hx, hy, $urandom_range(0, 1023), $urandom_range(0, 1023));
      n_checks++;
      if ({game_state, score_bcd, hi_bcd, length, eaten_pulse, apple_x, apple_y} !== model_outputs()) begin
        n_fail++;
        $display("FAIL random cycle %0d got %h want %h", n,
                 {game_state, score_bcd, hi_bcd, length, eaten_pulse, apple_x, apple_y}, model_outputs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_eat();
    test_hit_window();
    test_lowest_slot();
    test_over_restart();
    test_score_carry();
    test_max_length();
    test_reset_mid_play();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apple_score_engine.md
APPLE_SCORE_ENGINE -- requirements
Module: apple_score_engine

Interface
REQ-001 The block SHALL have parameter NUM_APPLES, default 2, number of simultaneous apple slots (legal 1..4).
REQ-002 The block SHALL have parameter COORD_W, default 10, coordinate width.
REQ-003 The block SHALL have parameter HIT_RADIUS, default 4, per-axis capture distance.
REQ-004 The block SHALL have parameters POINTS_PER_APPLE (default 4), SCORE_DIGITS (default 4) and MAX_LENGTH (default 100).
REQ-005 The block SHALL have parameters START_X (default 400), START_Y (default 200) and SLOT_STEP_X (default 64): slot i initial position is (START_X + i*SLOT_STEP_X, START_Y).
REQ-006 The block SHALL have port clock_100Mhz, input, 1 bit, sole clock; one clock only.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-008 The block SHALL have port step_tick, input, 1 bit, one-cycle pulse per snake move.
REQ-009 The block SHALL have port start, input, 1 bit, player start/restart request.
REQ-010 The block SHALL have port self_hit, input, 1 bit, collision flag, sampled only on step_tick.
REQ-011 The block SHALL have ports head_x and head_y, input, COORD_W each, snake head position.
REQ-012 The block SHALL have ports rand_x and rand_y, input, COORD_W each, respawn coordinates.
REQ-013 The block SHALL have ports apple_x and apple_y, output, NUM_APPLES*COORD_W each, slot i in bits [i*COORD_W +: COORD_W].
REQ-014 The block SHALL have ports length (output, 10 bits), score_bcd and hi_bcd (outputs, 4*SCORE_DIGITS each, digit 0 in the LSBs), eaten_pulse (output, 1 bit) and game_state (output, 2 bits).

Function
REQ-015 The FSM SHALL have states IDLE=00, PLAY=01 and OVER=10, presented on game_state.
REQ-016 IDLE->PLAY SHALL occur on start; on entry, score=0, length=1 and apples take their initial positions; hi_bcd is retained.
REQ-017 In PLAY, on step_tick with self_hit=1 or length==MAX_LENGTH, the FSM SHALL go to OVER; no scoring occurs on that tick.
REQ-018 OVER->IDLE SHALL occur on start; start SHALL be ignored in PLAY.
REQ-019 A hit on slot i SHALL mean |head_x-apple_x[i]|<=HIT_RADIUS and |head_y-apple_y[i]|<=HIT_RADIUS, evaluated with COORD_W+1-bit arithmetic so there is no underflow or wrap near 0 or the maximum coordinate.
REQ-020 Hits SHALL be evaluated only in PLAY on step_tick; at most one apple is eaten per tick, and the lowest slot index wins.
REQ-021 On an eaten tick, all of the following SHALL be registered one cycle after step_tick: the slot takes rand_x/rand_y, length+1 (saturating at MAX_LENGTH), score += POINTS_PER_APPLE in BCD with digit carry (saturating at all-9s), and eaten_pulse=1 for exactly one cycle.
REQ-022 Non-eaten slots SHALL hold their position.
REQ-023 When score_bcd > hi_bcd (unsigned digit-wise comparison), hi_bcd SHALL load score_bcd on the following cycle.
REQ-024 Outputs SHALL hold when step_tick=0.

Reset
REQ-025 Reset SHALL asynchronously force: game_state=IDLE, score_bcd=0, hi_bcd=0, length=1, eaten_pulse=0, and apples to their initial positions.
REQ-026 Reset asserted mid-PLAY SHALL abort play with no pending score or respawn applied after release.

Configuration
REQ-027 With macro APPLE_HIGH_SCORE_EN defined, hi_bcd tracking SHALL be per REQ-023.
REQ-028 Without APPLE_HIGH_SCORE_EN, hi_bcd SHALL be constant 0 and no comparison logic is instantiated.

Structure
REQ-029 Package snake_pkg SHALL hold the game_state encodings, BCD digit width (4) and default coordinate constants.
REQ-030 Sub-module bcd_adder SHALL implement saturating multi-digit BCD add of a constant.

Verification
REQ-031 Verification SHALL check: reset, start, head (400,200), step_tick -> game_state=01, then eaten_pulse 1 cycle, length=2, score_bcd=0x0004, slot0 = rand value.
REQ-032 Verification SHALL check: head at (404,196) -> hit; head at (405,200) -> no hit; apple at x=2 with head at x=1020 -> no wrap hit.
REQ-033 Verification SHALL check: head inside both slot0 and slot1 windows -> only slot0 respawns and score rises by 4 only.
REQ-034 Verification SHALL check: self_hit and an apple hit on the same tick -> game_state=10, score unchanged; start -> IDLE; start -> PLAY with hi_bcd retained.
REQ-035 Verification SHALL check: 25 apples eaten -> score_bcd=0x0100 with correct carry, hi_bcd=0x0100 one cycle later; with the macro undefined, hi_bcd=0.
REQ-036 Verification SHALL check: reset pulsed mid-PLAY during step_tick -> all outputs equal their REQ-025 values immediately.
